// File: rtl/fpsqrt_pkg.sv
// fpsqrt_pkg: formats, constants and helpers shared by the
// square-root datapath stages.
package fpsqrt_pkg;

    typedef enum logic [1:0] {
        FMT_H = 2'd0,
        FMT_S = 2'd1,
        FMT_D = 2'd2
    } fmt_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_NORM = 1'b1
    } state_e;

    localparam int EXP_W_H  = 5;
    localparam int EXP_W_S  = 8;
    localparam int EXP_W_D  = 11;
    localparam int FRAC_W_H = 10;
    localparam int FRAC_W_S = 23;
    localparam int FRAC_W_D = 52;

    localparam logic [10:0] BIAS_H = 11'd15;
    localparam logic [10:0] BIAS_S = 11'd127;
    localparam logic [10:0] BIAS_D = 11'd1023;

    localparam logic [63:0] QNAN_H = 64'h0000_0000_0000_7E00;
    localparam logic [63:0] QNAN_S = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] INF_H  = 64'h0000_0000_0000_7C00;
    localparam logic [63:0] INF_S  = 64'h0000_0000_7F80_0000;
    localparam logic [63:0] INF_D  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] SIGN_H = 64'h0000_0000_0000_8000;
    localparam logic [63:0] SIGN_S = 64'h0000_0000_8000_0000;
    localparam logic [63:0] SIGN_D = 64'h8000_0000_0000_0000;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    function automatic logic [10:0] bias_of(input logic [1:0] f);
        case (f)
            FMT_H:   return BIAS_H;
            FMT_S:   return BIAS_S;
            default: return BIAS_D;
        endcase
    endfunction

    function automatic logic [63:0] qnan_of(input logic [1:0] f);
        case (f)
            FMT_H:   return QNAN_H;
            FMT_S:   return QNAN_S;
            default: return QNAN_D;
        endcase
    endfunction

    function automatic logic [63:0] inf_of(input logic [1:0] f);
        case (f)
            FMT_H:   return INF_H;
            FMT_S:   return INF_S;
            default: return INF_D;
        endcase
    endfunction

    function automatic logic [63:0] sign_of(input logic [1:0] f);
        case (f)
            FMT_H:   return SIGN_H;
            FMT_S:   return SIGN_S;
            default: return SIGN_D;
        endcase
    endfunction

endpackage

// File: rtl/fpsqrt_pre_norm_step.sv
// fpsqrt_pre_norm_step: one normalisation step, a windowed
// leading-zero count plus left shift of the working significand.
module fpsqrt_pre_norm_step #(
    parameter int SHIFT_STEP = 16
) (
    input  logic [52:0] w,
    output logic [52:0] w_next,
    output logic [5:0]  shamt,
    output logic        done
);

    // Smallest set position in the window wins; empty window shifts fully.
    always_comb begin
        shamt = 6'(SHIFT_STEP);
        for (int i = SHIFT_STEP - 1; i >= 0; i--) begin
            if (w[52-i]) shamt = 6'(i);
        end
    end

    assign w_next = w << shamt;
    assign done   = w_next[52];

endmodule

// File: rtl/fpsqrt_pre_norm.sv
// fpsqrt_pre_norm: unpack, special-case resolve and normalise the
// sqrt operand. FPSQRT_PRE_SUBNORM_EN adds NORM; otherwise subnormals are DAZ.
module fpsqrt_pre_norm #(
    parameter int SHIFT_STEP = 16,
    parameter int EXP_W      = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid_i,
    output logic        start_ready_o,
    input  logic        flush_i,
    input  logic [1:0]  fmt_i,
    input  logic [63:0] op_i,
    input  logic [2:0]  rm_i,
    output logic        finish_valid_o,
    input  logic        finish_ready_i,
    output logic [52:0] frac_o,
    output logic        is_odd_o,
    output logic [11:0] res_exp_o,
    output logic [1:0]  fmt_o,
    output logic [2:0]  rm_o,
    output logic        special_o,
    output logic [63:0] special_res_o,
    output logic [4:0]  fflags_o
);
    import fpsqrt_pkg::*;

    logic        sgn;
    logic [10:0] e_fld;
    logic [10:0] e_max;
    logic [51:0] man;
    logic        e_zero;
    logic        is_nan;
    logic        is_zero;
    logic        is_inf;
    logic        is_special;
    logic        nv;
    logic [63:0] sres;
    logic        out_free;
    logic        accept;
    logic        load_out;
    logic        in_norm;
    logic [1:0]  f_sel;
    logic [10:0] bias;
    logic        odd_sel;
    logic signed [EXP_W-1:0] e_sel;
    logic signed [EXP_W-1:0] e_sum;
    logic signed [EXP_W-1:0] e_res;
    logic [52:0] d_frac;
    logic [11:0] d_exp;
    logic        d_odd;
    logic        d_special;
    logic [63:0] d_sres;
    logic [4:0]  d_flags;
    logic [1:0]  d_fmt;
    logic [2:0]  d_rm;
    logic        unused_ok;

    if (SHIFT_STEP < 1 || SHIFT_STEP > 53) begin : g_bad_step
        $error("fpsqrt_pre_norm: SHIFT_STEP must be 1..53");
    end

    // Field extraction; fmt 3 decodes as FP64.
    always_comb begin
        sgn   = op_i[63];
        e_fld = op_i[62:52];
        man   = op_i[51:0];
        e_max = 11'((1 << EXP_W_D) - 1);
        case (fmt_i)
            FMT_H: begin
                sgn   = op_i[FRAC_W_H+EXP_W_H];
                e_fld = 11'(op_i[FRAC_W_H +: EXP_W_H]);
                man   = {op_i[FRAC_W_H-1:0], {(FRAC_W_D-FRAC_W_H){1'b0}}};
                e_max = 11'((1 << EXP_W_H) - 1);
            end
            FMT_S: begin
                sgn   = op_i[FRAC_W_S+EXP_W_S];
                e_fld = 11'(op_i[FRAC_W_S +: EXP_W_S]);
                man   = {op_i[FRAC_W_S-1:0], {(FRAC_W_D-FRAC_W_S){1'b0}}};
                e_max = 11'((1 << EXP_W_S) - 1);
            end
            default: ;
        endcase
    end

    assign e_zero = (e_fld == 11'd0);
    assign is_nan = (e_fld == e_max) && (man != 52'd0);
    assign is_inf = (e_fld == e_max) && (man == 52'd0);
`ifdef FPSQRT_PRE_SUBNORM_EN
    assign is_zero = e_zero && (man == 52'd0);
`else
    assign is_zero = e_zero;
`endif
    assign is_special = is_nan || is_zero || sgn || is_inf;

    // Special result in priority order: NaN, zero, negative, inf.
    always_comb begin
        nv   = 1'b0;
        sres = 64'd0;
        if (is_nan) begin
            sres = qnan_of(fmt_i);
            nv   = !man[51];
        end else if (is_zero) begin
            sres = sgn ? sign_of(fmt_i) : 64'd0;
        end else if (sgn) begin
            sres = qnan_of(fmt_i);
            nv   = 1'b1;
        end else if (is_inf) begin
            sres = inf_of(fmt_i);
        end
    end

    assign out_free = !finish_valid_o || finish_ready_i;
    assign accept   = start_valid_i && start_ready_o;

`ifdef FPSQRT_PRE_SUBNORM_EN
    state_e      state_q;
    state_e      state_d;
    logic        load_w;
    logic [52:0] w_q;
    logic [52:0] step_w;
    logic [5:0]  shamt;
    logic        step_done;
    logic [1:0]  fmt_q;
    logic [2:0]  rm_q;
    logic signed [EXP_W-1:0] exp_q;
    logic signed [EXP_W-1:0] exp_nx;

    fpsqrt_pre_norm_step #(
        .SHIFT_STEP(SHIFT_STEP)
    ) u_step (
        .w     (w_q),
        .w_next(step_w),
        .shamt (shamt),
        .done  (step_done)
    );

    assign exp_nx        = exp_q - EXP_W'(shamt);
    assign in_norm       = (state_q == S_NORM);
    assign start_ready_o = !in_norm && out_free;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Subnormals detour through NORM; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        load_w   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (e_zero && !is_special) begin
                        load_w  = 1'b1;
                        state_d = S_NORM;
                    end else begin
                        load_out = 1'b1;
                    end
                end
            end
            S_NORM: begin
                if (step_done && out_free) begin
                    load_out = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d  = S_IDLE;
            load_out = 1'b0;
            load_w   = 1'b0;
        end
    end

    // Working significand: seeded on accept, stepped every NORM cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q   <= '0;
            exp_q <= '0;
            fmt_q <= '0;
            rm_q  <= '0;
        end else if (load_w) begin
            w_q   <= {1'b0, man};
            exp_q <= EXP_W'(1);
            fmt_q <= fmt_i;
            rm_q  <= rm_i;
        end else if (in_norm) begin
            w_q   <= step_w;
            exp_q <= exp_nx;
        end
    end
`else
    assign in_norm       = 1'b0;
    assign start_ready_o = out_free;
    assign load_out      = accept && !flush_i;
`endif

    // Result exponent and parity for the direct or the NORM path.
    always_comb begin
        e_sel = EXP_W'(e_fld);
        f_sel = fmt_i;
`ifdef FPSQRT_PRE_SUBNORM_EN
        if (in_norm) begin
            e_sel = exp_nx;
            f_sel = fmt_q;
        end
`endif
        bias    = bias_of(f_sel);
        e_sum   = e_sel + EXP_W'(bias);
        e_res   = e_sum >>> 1;
        odd_sel = e_sel[0] ^ bias[0];
    end

    assign unused_ok = ^e_res[EXP_W-1:12];

    // Next output payload.
    always_comb begin
        d_frac           = is_special ? 53'd0 : {1'b1, man};
        d_exp            = is_special ? 12'd0 : e_res[11:0];
        d_odd            = !is_special && odd_sel;
        d_special        = is_special;
        d_sres           = sres;
        d_flags          = 5'd0;
        d_flags[FF_NV]   = nv;
        d_fmt            = fmt_i;
        d_rm             = rm_i;
`ifdef FPSQRT_PRE_SUBNORM_EN
        if (in_norm) begin
            d_frac    = step_w;
            d_exp     = e_res[11:0];
            d_odd     = odd_sel;
            d_special = 1'b0;
            d_sres    = 64'd0;
            d_flags   = 5'd0;
            d_fmt     = fmt_q;
            d_rm      = rm_q;
        end
`endif
    end

    // Output register: holds until drained; flush drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finish_valid_o <= 1'b0;
            frac_o         <= '0;
            is_odd_o       <= 1'b0;
            res_exp_o      <= '0;
            fmt_o          <= '0;
            rm_o           <= '0;
            special_o      <= 1'b0;
            special_res_o  <= '0;
            fflags_o       <= '0;
        end else if (flush_i) begin
            finish_valid_o <= 1'b0;
        end else if (load_out) begin
            finish_valid_o <= 1'b1;
            frac_o         <= d_frac;
            is_odd_o       <= d_odd;
            res_exp_o      <= d_exp;
            fmt_o          <= d_fmt;
            rm_o           <= d_rm;
            special_o      <= d_special;
            special_res_o  <= d_sres;
            fflags_o       <= d_flags;
        end else if (finish_ready_i) begin
            finish_valid_o <= 1'b0;
        end
    end

endmodule
